// File: rtl/aes_kat_sequencer_if.sv
// Handshake and data bus between the KAT sequencer and the shared iterative AES engine.
interface aes_kat_sequencer_if;
  logic         core_start;
  logic         core_decrypt;
  logic [1:0]   core_keylen;
  logic [255:0] core_key;
  logic [127:0] core_din;
  logic         core_done;
  logic [127:0] core_dout;

  modport master (
    output core_start, core_decrypt, core_keylen, core_key, core_din,
    input  core_done, core_dout
  );

  modport slave (
    input  core_start, core_decrypt, core_keylen, core_key, core_din,
    output core_done, core_dout
  );
endinterface

// File: rtl/aes_kat_sequencer.sv
// AES built-in self-test: runs the six FIPS-197 Appendix C vectors through one shared
// engine, compares each result and latches a pass flag per vector.
module aes_kat_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  aes_kat_sequencer_if.master        core,
  output logic                       busy,
  output logic                       done,
  output logic [5:0]                 pass,
  output logic                       all_pass,
  output logic                       timeout_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192 = {K128, 64'h1011121314151617};
  localparam logic [255:0] K256 = {K192, 64'h18191a1b1c1d1e1f};
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic [127:0]  res_q;
  logic          to_q;
  logic          ran_q;

  logic          vec_dec;
  logic [1:0]    vec_kl;
  logic [255:0]  vec_key;
  logic [127:0]  vec_cipher;
  logic [127:0]  vec_din;
  logic [127:0]  vec_exp;

  // Indices 0-2 encrypt, 3-5 decrypt; key length cycles 128/192/256 within each half.
  always_comb begin
    vec_dec    = (idx_q >= 3'd3);
    vec_kl     = vec_dec ? 2'(idx_q - 3'd3) : idx_q[1:0];
    vec_key    = '0;
    vec_cipher = '0;
    case (vec_kl)
      2'b00: begin
        vec_key    = {K128, 128'h0};
        vec_cipher = C128;
      end
      2'b01: begin
        vec_key    = {K192, 64'h0};
        vec_cipher = C192;
      end
      default: begin
        vec_key    = K256;
        vec_cipher = C256;
      end
    endcase
    vec_din = vec_dec ? vec_cipher : PT;
    vec_exp = vec_dec ? PT : vec_cipher;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    busy              = (state_q != IDLE);
    done              = 1'b0;
    core.core_start   = 1'b0;
    core.core_decrypt = 1'b0;
    core.core_keylen  = 2'b00;
    core.core_key     = '0;
    core.core_din     = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = ISSUE;
      end
      ISSUE: begin
        core.core_start   = 1'b1;
        core.core_decrypt = vec_dec;
        core.core_keylen  = vec_kl;
        core.core_key     = vec_key;
        core.core_din     = vec_din;
        state_d           = WAIT;
      end
      WAIT: begin
        core.core_decrypt = vec_dec;
        core.core_keylen  = vec_kl;
        core.core_key     = vec_key;
        core.core_din     = vec_din;
        if (core.core_done || (cnt_q == CNT_LAST)) state_d = CHECK;
      end
      CHECK: begin
        state_d = (idx_q == 3'd5) ? FINISH : ISSUE;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // all_pass is valid from the done cycle until the next accepted start.
  assign all_pass = (ran_q || (state_q == FINISH)) && (&pass);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      to_q        <= 1'b0;
      ran_q       <= 1'b0;
      pass        <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q       <= '0;
            pass        <= '0;
            timeout_err <= 1'b0;
            ran_q       <= 1'b0;
          end
        end
        ISSUE: begin
          cnt_q <= '0;
          to_q  <= 1'b0;
        end
        WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (core.core_done) begin
            res_q <= core.core_dout;
          end else if (cnt_q == CNT_LAST) begin
            to_q        <= 1'b1;
            timeout_err <= 1'b1;
          end
        end
        CHECK: begin
          pass[idx_q] <= (res_q == vec_exp) && !to_q;
          if (idx_q != 3'd5) idx_q <= idx_q + 3'd1;
        end
        FINISH: begin
          ran_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Self-checking bench for aes_kat_sequencer: a lookup-based engine model with random
// latency and fault injection, checked against the expected vector sequence and results.
module tb_aes_kat_sequencer;

  localparam int unsigned TO = 64;

  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192 = {K128, 64'h1011121314151617};
  localparam logic [255:0] K256 = {K192, 64'h18191a1b1c1d1e1f};
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, all_pass, timeout_err;
  logic [5:0] pass;

  int n_checks = 0;
  int n_bad    = 0;

  aes_kat_sequencer_if bus();

  aes_kat_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .core       (bus),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .all_pass   (all_pass),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] key_of(input int kl);
    if (kl == 0)      return {K128, 128'h0};
    else if (kl == 1) return {K192, 64'h0};
    else              return K256;
  endfunction

  function automatic logic [127:0] cipher_of(input int kl);
    if (kl == 0)      return C128;
    else if (kl == 1) return C192;
    else              return C256;
  endfunction

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine model: answers known vectors correctly, garbage otherwise; optional bit-0 flip.
  int         eng_lat  = 11;
  logic [5:0] eng_flip = '0;
  logic       eng_done = 1'b0;
  logic       spur     = 1'b0;
  logic [127:0] eng_dout = '0;
  logic [127:0] pend     = '0;
  int         rem      = 0;

  function automatic logic [127:0] engine_result(input logic dec, input logic [1:0] kl,
                                                 input logic [255:0] key, input logic [127:0] din);
    logic [127:0] c;
    c = cipher_of(int'(kl));
    if (kl == 2'b11 || key != key_of(int'(kl))) return ~c ^ PT;
    if (dec) return (din == c)  ? PT : ~PT;
    else     return (din == PT) ? c  : ~c;
  endfunction

  always @(posedge clk) begin : engine
    logic [127:0] r;
    int vi;
    eng_done <= 1'b0;
    if (bus.core_start) begin
      r  = engine_result(bus.core_decrypt, bus.core_keylen, bus.core_key, bus.core_din);
      vi = (bus.core_decrypt ? 3 : 0) + int'(bus.core_keylen);
      if (vi < 6 && eng_flip[vi]) r[0] = ~r[0];
      if (eng_lat == 1) begin
        eng_done <= 1'b1;
        eng_dout <= r;
        rem      <= 0;
      end else if (eng_lat > 1) begin
        rem  <= eng_lat - 1;
        pend <= r;
      end else begin
        rem <= 0;
      end
    end else if (rem != 0) begin
      rem <= rem - 1;
      if (rem == 1) begin
        eng_done <= 1'b1;
        eng_dout <= pend;
      end
    end
  end

  assign bus.core_done = eng_done | spur;
  assign bus.core_dout = spur ? 128'hdeadbeefdeadbeefdeadbeefdeadbeef : eng_dout;

  task automatic check_idle_outputs(input string pfx);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_done"}, done, 0);
    check_eq({pfx, "_pass"}, pass, 0);
    check_eq({pfx, "_all_pass"}, all_pass, 0);
    check_eq({pfx, "_timeout"}, timeout_err, 0);
    check_eq({pfx, "_cstart"}, bus.core_start, 0);
    check_eq({pfx, "_cdec"}, bus.core_decrypt, 0);
    check_eq({pfx, "_ckeylen"}, bus.core_keylen, 0);
    check_eq({pfx, "_ckey"}, bus.core_key, 0);
    check_eq({pfx, "_cdin"}, bus.core_din, 0);
  endtask

  // Caller is at a negedge with the DUT idle. Start is sampled at the next posedge (edge 0);
  // loop index n is the cycle number counted from there.
  task automatic do_run(input int lat, input logic [5:0] flip, input bit hold,
                        input bit mid_start, input bit spur_issue);
    int leff, k, dec, kl;
    bit seen, to;
    logic [5:0] exp_pass;
    to       = (lat == 0 || lat > int'(TO));
    leff     = to ? int'(TO) : lat;
    exp_pass = to ? 6'b0 : ~flip;
    eng_lat  = lat;
    eng_flip = flip;
    start    = 1'b1;
    @(posedge clk);
    k    = 0;
    seen = 1'b0;
    for (int n = 1; n <= 6 * (leff + 2) + 10; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (!hold) start = 1'b0;
        check_eq("clear_pass", pass, 0);
        check_eq("clear_all_pass", all_pass, 0);
        check_eq("clear_timeout", timeout_err, 0);
      end
      if (mid_start) begin
        if (n == 30) start = 1'b1;
        if (n == 31) start = 1'b0;
      end
      if (spur_issue) spur = (n == 1);
      if (bus.core_start) begin
        check_eq($sformatf("start%0d_cycle", k), n, 1 + k * (leff + 2));
        if (k < 6) begin
          dec = (k >= 3) ? 1 : 0;
          kl  = k % 3;
          check_eq($sformatf("start%0d_dec", k), bus.core_decrypt, dec);
          check_eq($sformatf("start%0d_keylen", k), bus.core_keylen, kl);
          check_eq($sformatf("start%0d_key", k), bus.core_key, key_of(kl));
          check_eq($sformatf("start%0d_din", k), bus.core_din, dec ? cipher_of(kl) : PT);
        end
        k++;
      end
      if (done) begin
        check_eq("done_cycle", n, 6 * (leff + 2) + 1);
        check_eq("starts", k, 6);
        check_eq("pass", pass, exp_pass);
        check_eq("all_pass", all_pass, &exp_pass);
        check_eq("timeout_err", timeout_err, to);
        check_eq("busy_at_done", busy, 1);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq("done_seen", 0, 1);
    @(negedge clk);
    check_eq("post_busy", busy, 0);
    check_eq("post_done", done, 0);
    check_eq("post_all_pass", all_pass, &exp_pass);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int k, w, ndone;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    do_run(11, 6'b000000, 0, 0, 0);
    do_run(11, 6'b000010, 0, 0, 0);
    do_run(0,  6'b000000, 0, 0, 0);

    // Abort during WAIT of vector 3.
    eng_lat  = 11;
    eng_flip = '0;
    start    = 1'b1;
    @(posedge clk);
    k = 0;
    w = 0;
    for (int n = 1; n < 200 && w < 3; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (bus.core_start) k++;
      if (k == 4) w++;
    end
    check_eq("rst_reach_vec3", k, 4);
    check_eq("pre_rst_pass", pass, 6'b000111);
    rst = 1'b1;
    #1;
    check_idle_outputs("abort");
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check_eq("no_done_after_abort", ndone, 0);
    do_run(11, 6'b000000, 0, 0, 0);

    // Spurious core_done while idle, then a run with mid-run start and spurious done in ISSUE.
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check_eq("spur_idle_busy", busy, 0);
    check_eq("spur_idle_done", done, 0);
    do_run(11, 6'b000000, 0, 1, 1);

    // Back-to-back with start held high.
    do_run(11, 6'b000000, 1, 0, 0);
    do_run(11, 6'b000000, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      int lat;
      logic [5:0] fl;
      if (i == 0)      lat = 64;
      else if (i == 1) lat = 65;
      else             lat = int'($urandom_range(1, 66));
      fl = 6'($urandom_range(0, 63));
      if (i == 0) fl = '0;
      do_run(lat, fl, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
